// File: rtl/spi_sensor_poller.sv
// spi_sensor_poller
// Periodically reads one sensor register through the SPI byte engine:
// a command-byte transfer, then a dummy-byte read transfer. The received
// byte is published as a sample and compared against an unsigned threshold,
// driving a latched alarm flag and a sticky timeout error.

module spi_sensor_poller #(
   parameter int                   REG_WIDTH = 8,
   parameter int                   POLL_DIV  = 50000,
   parameter logic [REG_WIDTH-1:0] CMD_BYTE  = 8'h8F,
   parameter int                   TIMEOUT   = 255
) (
   input  logic                           clk_system,
   input  logic                           reset_system,
   input  logic                           enable,
   input  logic [REG_WIDTH-1:0]           threshold,
   input  logic                           alarm_clear,
   output logic                           spi_start,
   output logic [REG_WIDTH-1:0]           spi_tx,
   output logic [$clog2(REG_WIDTH):0]     spi_size,
   input  logic                           spi_done,
   input  logic [REG_WIDTH-1:0]           spi_rx,
   output logic [REG_WIDTH-1:0]           sample,
   output logic                           sample_valid,
   output logic                           alarm,
   output logic                           timeout_err
);

   localparam int SIZE_W = $clog2(REG_WIDTH) + 1;
   localparam int TICK_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int TO_W   = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      SEND_CMD,
      WAIT_CMD,
      SEND_RD,
      WAIT_RD,
      COMPARE,
      ABORT
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [TICK_W-1:0] tick_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              tick;
   logic              timeout_hit;

   assign tick        = (tick_cnt == TICK_W'(POLL_DIV - 1));
   assign timeout_hit = (to_cnt == TO_W'(TIMEOUT));
   assign spi_size    = SIZE_W'(REG_WIDTH);

   // Poll interval counter: free-runs while enabled, parked at zero otherwise.
   always_ff @(posedge clk_system or negedge reset_system) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset_system)
         tick_cnt <= '0;
      else if (!enable || tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TICK_W'(1);
   end

   // State register.
   always_ff @(posedge clk_system or negedge reset_system) begin
      if (!reset_system)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic; ticks arriving mid-poll are simply not looked at.
   always_comb begin
      // NOTE: default first so every path assigns next_state and no latch is inferred.
      next_state = state;
      unique case (state)
         IDLE:      if (enable) next_state = WAIT_TICK;
         WAIT_TICK: begin
            if (!enable)   next_state = IDLE;
            else if (tick) next_state = SEND_CMD;
         end
         SEND_CMD:  next_state = WAIT_CMD;
         WAIT_CMD: begin
            if (spi_done)         next_state = SEND_RD;
            else if (timeout_hit) next_state = ABORT;
         end
         SEND_RD:   next_state = WAIT_RD;
         WAIT_RD: begin
            if (spi_done)         next_state = COMPARE;
            else if (timeout_hit) next_state = ABORT;
         end
         COMPARE,
         ABORT:     next_state = enable ? WAIT_TICK : IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // Response watchdog: cleared while issuing a request, counts while waiting.
   always_ff @(posedge clk_system or negedge reset_system) begin
      if (!reset_system)
         to_cnt <= '0;
      else if (state == SEND_CMD || state == SEND_RD)
         to_cnt <= '0;
      else if ((state == WAIT_CMD || state == WAIT_RD) && !timeout_hit)
         to_cnt <= to_cnt + TO_W'(1);
   end

   // Engine request: start pulse and transmit word, held until the next request.
   always_ff @(posedge clk_system or negedge reset_system) begin
      if (!reset_system) begin
         spi_start <= 1'b0;
         spi_tx    <= '0;
      end else begin
         spi_start <= (next_state == SEND_CMD) || (next_state == SEND_RD);
         if (next_state == SEND_CMD)
            spi_tx <= CMD_BYTE;
         else if (next_state == SEND_RD)
            spi_tx <= '0;
      end
   end

   // Sample capture on the read transfer's completion, valid pulse after compare.
   always_ff @(posedge clk_system or negedge reset_system) begin
      if (!reset_system) begin
         sample       <= '0;
         sample_valid <= 1'b0;
      end else begin
         if (state == WAIT_RD && spi_done)
            sample <= spi_rx;
         sample_valid <= (state == COMPARE);
      end
   end

   // Latched flags: a set in the same cycle as alarm_clear takes priority.
   always_ff @(posedge clk_system or negedge reset_system) begin
      if (!reset_system) begin
         alarm       <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (state == COMPARE && sample > threshold)
            alarm <= 1'b1;
         else if (alarm_clear)
            alarm <= 1'b0;
         if (state == ABORT)
            timeout_err <= 1'b1;
         else if (alarm_clear)
            timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Directed testbench for spi_sensor_poller. Two instances share reset:
// u_dut talks to a behavioural SPI engine that answers 10 cycles after each
// start; u_to (TIMEOUT=8) gets no spi_done at all.

module tb_spi_sensor_poller;

   logic       clk_system = 1'b0;
   logic       reset_system;
   logic       enable;
   logic       alarm_clear;
   logic [7:0] threshold;
   logic       spi_done;
   logic [7:0] spi_rx;
   logic       spi_start;
   logic [7:0] spi_tx;
   logic [3:0] spi_size;
   logic [7:0] sample;
   logic       sample_valid;
   logic       alarm;
   logic       timeout_err;

   logic       enable_to;
   logic       clear_to;
   logic       done_to;
   logic [7:0] rx_to;
   logic       start_to;
   logic [7:0] tx_to;
   logic [3:0] size_to;
   logic [7:0] sample_to;
   logic       sv_to;
   logic       alarm_to;
   logic       err_to;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] rx_value;
   logic [7:0] tx_log[$];
   int         eng_cnt;

   always #5 clk_system = ~clk_system;

   spi_sensor_poller #(
      .REG_WIDTH(8), .POLL_DIV(16), .CMD_BYTE(8'h8F), .TIMEOUT(32)
   ) u_dut (
      .clk_system  (clk_system),
      .reset_system(reset_system),
      .enable      (enable),
      .threshold   (threshold),
      .alarm_clear (alarm_clear),
      .spi_start   (spi_start),
      .spi_tx      (spi_tx),
      .spi_size    (spi_size),
      .spi_done    (spi_done),
      .spi_rx      (spi_rx),
      .sample      (sample),
      .sample_valid(sample_valid),
      .alarm       (alarm),
      .timeout_err (timeout_err)
   );

   spi_sensor_poller #(
      .REG_WIDTH(8), .POLL_DIV(16), .CMD_BYTE(8'h8F), .TIMEOUT(8)
   ) u_to (
      .clk_system  (clk_system),
      .reset_system(reset_system),
      .enable      (enable_to),
      .threshold   (threshold),
      .alarm_clear (clear_to),
      .spi_start   (start_to),
      .spi_tx      (tx_to),
      .spi_size    (size_to),
      .spi_done    (done_to),
      .spi_rx      (rx_to),
      .sample      (sample_to),
      .sample_valid(sv_to),
      .alarm       (alarm_to),
      .timeout_err (err_to)
   );

   // SPI engine model: logs each transmitted word, pulses spi_done 10 cycles after start.
   initial begin
      spi_done = 1'b0;
      spi_rx   = 8'h00;
      eng_cnt  = 0;
      forever begin
         @(posedge clk_system);
         #1;
         spi_done = 1'b0;
         if (!reset_system) begin
            eng_cnt = 0;
         end else begin
            if (eng_cnt == 1) begin
               spi_done = 1'b1;
               spi_rx   = rx_value;
            end
            if (eng_cnt != 0) eng_cnt--;
            if (spi_start === 1'b1) begin
               tx_log.push_back(spi_tx);
               eng_cnt = 10;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_system);
         #1;
      end
   endtask

   // Waits (bounded) for a start pulse on the chosen instance; n = edges waited.
   task automatic wait_start(input bit use_to, input int maxc, output int n);
      n = 0;
      while (((use_to ? start_to : spi_start) !== 1'b1) && n < maxc) begin
         step(1);
         n++;
      end
      checks++;
      if ((use_to ? start_to : spi_start) !== 1'b1) begin
         $display("FAIL wait_start no spi_start within %0d cycles", maxc);
         failures++;
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({spi_start, spi_tx, sample, sample_valid, alarm, timeout_err} !== 20'h0) begin
         $display("FAIL reset_outputs actual=%h expected=0",
                  {spi_start, spi_tx, sample, sample_valid, alarm, timeout_err});
         failures++;
      end
      checks++;
      if (spi_size !== 4'd8) begin
         $display("FAIL reset_spi_size actual=%0d expected=8", spi_size);
         failures++;
      end
      checks++;
      if ({start_to, tx_to, sample_to, sv_to, alarm_to, err_to} !== 20'h0) begin
         $display("FAIL reset_outputs_to actual=%h expected=0",
                  {start_to, tx_to, sample_to, sv_to, alarm_to, err_to});
         failures++;
      end
      step(2);
      reset_system = 1'b1;
      step(2);
   endtask

   task automatic test_timeout();
      int n;
      enable_to = 1'b1;
      wait_start(1'b1, 30, n);
      checks++;
      if (n !== 16) begin
         $display("FAIL to_first_start actual=%0d expected=16", n);
         failures++;
      end
      // start at S; WAIT_CMD S+1..S+9 (count 0..8), ABORT S+10, flag at S+11
      step(10);
      checks++;
      if (err_to !== 1'b0) begin
         $display("FAIL to_err_early actual=%b expected=0", err_to);
         failures++;
      end
      step(1);
      checks++;
      if (err_to !== 1'b1 || sample_to !== 8'h00 || sv_to !== 1'b0) begin
         $display("FAIL to_err_set err=%b sample=%h valid=%b expected err=1 sample=00 valid=0",
                  err_to, sample_to, sv_to);
         failures++;
      end
      step(4);
      checks++;
      if (start_to !== 1'b0) begin
         $display("FAIL to_no_early_start actual=%b expected=0", start_to);
         failures++;
      end
      step(1);
      checks++;
      if (start_to !== 1'b1 || tx_to !== 8'h8F) begin
         $display("FAIL to_fresh_poll start=%b tx=%h expected start=1 tx=8f", start_to, tx_to);
         failures++;
      end
      clear_to = 1'b1;
      step(1);
      clear_to = 1'b0;
      checks++;
      if (err_to !== 1'b0) begin
         $display("FAIL to_err_clear actual=%b expected=0", err_to);
         failures++;
      end
      enable_to = 1'b0;
   endtask

   task automatic test_normal();
      int n;
      threshold = 8'h50;
      rx_value  = 8'h40;
      tx_log.delete();
      enable = 1'b1;
      wait_start(1'b0, 30, n);
      checks++;
      if (n !== 16) begin
         $display("FAIL first_start_latency actual=%0d expected=16", n);
         failures++;
      end
      step(5);
      checks++;
      if (spi_tx !== 8'h8F) begin
         $display("FAIL cmd_tx_held actual=%h expected=8f", spi_tx);
         failures++;
      end
      step(16);
      checks++;
      if (spi_tx !== 8'h00 || sample !== 8'h00) begin
         $display("FAIL wait_rd tx=%h sample=%h expected tx=00 sample=00", spi_tx, sample);
         failures++;
      end
      step(1);
      checks++;
      if (sample !== 8'h40 || sample_valid !== 1'b0) begin
         $display("FAIL sample_update sample=%h valid=%b expected sample=40 valid=0",
                  sample, sample_valid);
         failures++;
      end
      step(1);
      checks++;
      if (sample_valid !== 1'b1 || alarm !== 1'b0) begin
         $display("FAIL sample_valid valid=%b alarm=%b expected valid=1 alarm=0",
                  sample_valid, alarm);
         failures++;
      end
      step(1);
      checks++;
      if (sample_valid !== 1'b0) begin
         $display("FAIL valid_one_cycle actual=%b expected=0", sample_valid);
         failures++;
      end
      checks++;
      if (tx_log.size() != 2 || tx_log[0] !== 8'h8F || tx_log[1] !== 8'h00) begin
         $display("FAIL tx_sequence count=%0d expected 2 words 8f,00", tx_log.size());
         failures++;
      end
   endtask

   task automatic test_alarm_latch();
      int n;
      rx_value = 8'h51;
      wait_start(1'b0, 40, n);
      step(23);
      checks++;
      if (sample !== 8'h51 || sample_valid !== 1'b1 || alarm !== 1'b1) begin
         $display("FAIL alarm_set sample=%h valid=%b alarm=%b expected 51,1,1",
                  sample, sample_valid, alarm);
         failures++;
      end
      rx_value = 8'h10;
      wait_start(1'b0, 40, n);
      step(23);
      checks++;
      if (sample !== 8'h10 || sample_valid !== 1'b1 || alarm !== 1'b1) begin
         $display("FAIL alarm_held sample=%h valid=%b alarm=%b expected 10,1,1",
                  sample, sample_valid, alarm);
         failures++;
      end
      alarm_clear = 1'b1;
      step(1);
      alarm_clear = 1'b0;
      checks++;
      if (alarm !== 1'b0) begin
         $display("FAIL alarm_clear actual=%b expected=0", alarm);
         failures++;
      end
      // clear pulse lands in the COMPARE cycle of an alarming sample: set wins
      rx_value = 8'h60;
      wait_start(1'b0, 40, n);
      step(22);
      alarm_clear = 1'b1;
      step(1);
      alarm_clear = 1'b0;
      checks++;
      if (alarm !== 1'b1 || sample_valid !== 1'b1) begin
         $display("FAIL set_beats_clear alarm=%b valid=%b expected alarm=1 valid=1",
                  alarm, sample_valid);
         failures++;
      end
      alarm_clear = 1'b1;
      step(1);
      alarm_clear = 1'b0;
      checks++;
      if (alarm !== 1'b0) begin
         $display("FAIL alarm_clear_again actual=%b expected=0", alarm);
         failures++;
      end
   endtask

   task automatic test_equal();
      int n;
      rx_value = 8'h50;
      wait_start(1'b0, 40, n);
      step(23);
      checks++;
      if (sample !== 8'h50 || sample_valid !== 1'b1 || alarm !== 1'b0) begin
         $display("FAIL equal_no_alarm sample=%h valid=%b alarm=%b expected 50,1,0",
                  sample, sample_valid, alarm);
         failures++;
      end
   endtask

   task automatic test_enable_drop();
      int  n;
      bit  seen_start;
      rx_value = 8'h90;
      wait_start(1'b0, 40, n);
      step(15);
      enable = 1'b0;
      step(8);
      checks++;
      if (sample !== 8'h90 || sample_valid !== 1'b1 || alarm !== 1'b1) begin
         $display("FAIL drop_completes sample=%h valid=%b alarm=%b expected 90,1,1",
                  sample, sample_valid, alarm);
         failures++;
      end
      seen_start = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step(1);
         if (spi_start === 1'b1) seen_start = 1'b1;
      end
      checks++;
      if (seen_start) begin
         $display("FAIL start_while_disabled actual=1 expected=0");
         failures++;
      end
   endtask

   task automatic test_async_reset();
      int n;
      enable = 1'b1;
      wait_start(1'b0, 30, n);
      checks++;
      if (n !== 16) begin
         $display("FAIL reenable_latency actual=%0d expected=16", n);
         failures++;
      end
      step(3);
      #3;
      reset_system = 1'b0;
      #1;
      checks++;
      if ({spi_start, spi_tx, sample, sample_valid, alarm, timeout_err} !== 20'h0 ||
          spi_size !== 4'd8) begin
         $display("FAIL async_reset outputs=%h size=%0d expected outputs=0 size=8",
                  {spi_start, spi_tx, sample, sample_valid, alarm, timeout_err}, spi_size);
         failures++;
      end
      step(1);
      reset_system = 1'b1;
      wait_start(1'b0, 40, n);
      checks++;
      if (n !== 16 || spi_tx !== 8'h8F) begin
         $display("FAIL post_reset_start wait=%0d tx=%h expected wait=16 tx=8f", n, spi_tx);
         failures++;
      end
   endtask

   initial begin
      reset_system = 1'b0;
      enable       = 1'b0;
      alarm_clear  = 1'b0;
      threshold    = 8'h50;
      rx_value     = 8'h00;
      enable_to    = 1'b0;
      clear_to     = 1'b0;
      done_to      = 1'b0;
      rx_to        = 8'h00;

      test_reset();
      test_timeout();
      test_normal();
      test_alarm_latch();
      test_equal();
      test_enable_drop();
      test_async_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
